// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request, data-memory and response bus of the load/store unit
interface load_store_unit_if #(
  parameter int ADDR_W = 16
);
  // execute -> LSU request
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;

  // LSU <-> data memory
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  // LSU -> writeback response
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic [4:0]        rsp_rd;
  logic              rsp_err;

  // the load/store unit itself
  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output rsp_valid, rsp_data, rsp_rd, rsp_err
  );

  // the surrounding core / memory environment
  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  rsp_valid, rsp_data, rsp_rd, rsp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I memory stage: byte-lane stores, extended loads, output port (optional MISALIGN_TRAP_EN)
module load_store_unit #(
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] OUTPORT_ADR = 16'hfffc
) (
  input  logic                    clk,
  input  logic                    rst_n,
  load_store_unit_if.slave        bus,
  output logic [31:0]             outport
);

  // funct3 encodings shared by loads and stores
  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_HALF   = 3'b001;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  localparam logic [2:0] F3_HALF_U = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;

  // captured op context needed after the accept cycle
  logic [2:0]  op_funct3;
  logic [1:0]  op_lane;
  logic [4:0]  op_rd;

  // request decode, valid only while a request is presented in IDLE
  logic        f3_legal;
  logic        misaligned;
  logic        is_outport;
  logic [1:0]  byte_off;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [ADDR_W-1:0] word_addr;

  // load extraction from the returned word
  logic [31:0] rdata_shifted;
  logic [31:0] load_ext;

  // Decode the presented request: legality, byte enables, replicated store data.
  always_comb begin
    f3_legal   = 1'b0;
    misaligned = 1'b0;
    is_outport = 1'b0;
    be         = 4'b0000;
    wdata_rep  = 32'h0;
    lane       = 2'b00;
    byte_off   = bus.req_addr[1:0];
    word_addr  = {bus.req_addr[ADDR_W-1:2], 2'b00};

    if (bus.req_store) begin
      f3_legal = (bus.req_funct3 == F3_BYTE) ||
                 (bus.req_funct3 == F3_HALF) ||
                 (bus.req_funct3 == F3_WORD);
    end else begin
      f3_legal = (bus.req_funct3 == F3_BYTE)   ||
                 (bus.req_funct3 == F3_HALF)   ||
                 (bus.req_funct3 == F3_WORD)   ||
                 (bus.req_funct3 == F3_BYTE_U) ||
                 (bus.req_funct3 == F3_HALF_U);
    end

`ifdef MISALIGN_TRAP_EN
    // Halfwords must be 2-byte aligned and words 4-byte aligned.
    if ((bus.req_funct3[1:0] == 2'b01) && byte_off[0]) begin
      misaligned = 1'b1;
    end
    if ((bus.req_funct3[1:0] == 2'b10) && (byte_off != 2'b00)) begin
      misaligned = 1'b1;
    end
`endif

    // Width comes from funct3[1:0]; the unsigned variants share lanes with signed ones.
    // Without the trap, stray low address bits are dropped: halves use addr[1], words lane 0.
    case (bus.req_funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << byte_off;
        wdata_rep = {4{bus.req_wdata[7:0]}};
        lane      = byte_off;
      end
      2'b01: begin
        be        = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{bus.req_wdata[15:0]}};
        lane      = {byte_off[1], 1'b0};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = bus.req_wdata;
        lane      = 2'b00;
      end
    endcase

    is_outport = bus.req_store && (bus.req_funct3 == F3_WORD) &&
                 (bus.req_addr == OUTPORT_ADR);
  end

  // Align the addressed lane to bit 0 and sign/zero-extend by the captured funct3.
  always_comb begin
    rdata_shifted = bus.mem_rdata >> {op_lane, 3'b000};
    load_ext      = rdata_shifted;
    case (op_funct3)
      F3_BYTE:   load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      F3_HALF:   load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      F3_BYTE_U: load_ext = {24'h0, rdata_shifted[7:0]};
      F3_HALF_U: load_ext = {16'h0, rdata_shifted[15:0]};
      default:   load_ext = rdata_shifted;
    endcase
  end

  // Op sequencer with registered memory and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      op_funct3     <= 3'b000;
      op_lane       <= 2'b00;
      op_rd         <= 5'd0;
      outport       <= 32'h0;
      bus.req_ready <= 1'b1;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= 4'b0000;
      bus.mem_wdata <= 32'h0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 32'h0;
      bus.rsp_rd    <= 5'd0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            op_funct3     <= bus.req_funct3;
            op_lane       <= lane;
            op_rd         <= bus.req_rd;
            if (!f3_legal || misaligned) begin
              // Rejected op: answer immediately, never touch memory.
              state         <= S_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_data  <= 32'h0;
              bus.rsp_rd    <= 5'd0;
            end else if (is_outport) begin
              // Output-port write completes locally in one cycle.
              outport       <= bus.req_wdata;
              state         <= S_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b0;
              bus.rsp_data  <= 32'h0;
              bus.rsp_rd    <= 5'd0;
            end else begin
              state         <= S_REQ;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.req_store;
              bus.mem_addr  <= word_addr;
              bus.mem_be    <= be;
              bus.mem_wdata <= bus.req_store ? wdata_rep : 32'h0;
            end
          end
        end

        S_REQ: begin
          // Address phase held stable until the memory grants it.
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            if (bus.mem_we) begin
              state         <= S_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b0;
              bus.rsp_data  <= 32'h0;
              bus.rsp_rd    <= 5'd0;
            end else begin
              state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (bus.mem_rvalid) begin
            state         <= S_RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_data  <= load_ext;
            bus.rsp_rd    <= op_rd;
          end
        end

        S_RESP: begin
          // Single-cycle completion pulse, then reopen for the next op.
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
          bus.rsp_data  <= 32'h0;
          bus.rsp_rd    <= 5'd0;
        end

        default: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
